// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: owns the framebuffer RAM write port. Shares it between two
// pixel-writing players (round-robin) and a full-screen clear sweep that runs
// after reset or on request. Coordinates are turned into linear addresses here.
module fb_write_arbiter #(
    parameter int   WIDTH       = 640,
    parameter int   HEIGHT      = 480,
    parameter int   ADDR_W      = 19,
    parameter int   XY_W        = 11,
    parameter logic CLEAR_VALUE = 1'b0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear_req,
    input  logic              i_req0,
    input  logic [XY_W-1:0]   i_x0,
    input  logic [XY_W-1:0]   i_y0,
    input  logic              i_data0,
    input  logic              i_req1,
    input  logic [XY_W-1:0]   i_x1,
    input  logic [XY_W-1:0]   i_y1,
    input  logic              i_data1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_err0,
    output logic              o_err1,
    output logic [ADDR_W-1:0] o_ram_write_address,
    output logic              o_ram_write_data,
    output logic              o_ram_write_enabled,
    output logic              o_ready
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [XY_W-1:0]   W_XY      = XY_W'(WIDTH);
    localparam logic [XY_W-1:0]   H_XY      = XY_W'(HEIGHT);

    // Registered state and outputs
    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_rr_ptr;      // player favoured when both are eligible
    logic [1:0]          r_ack;
    logic [1:0]          r_err;
    logic                r_wren;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_data;
    logic                r_ready;

    // Next-state values
    state_t              w_state_next;
    logic [ADDR_W-1:0]   w_clr_cnt_next;
    logic                w_rr_ptr_next;
    logic [1:0]          w_ack_next;
    logic [1:0]          w_err_next;
    logic                w_wren_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic                w_data_next;
    logic                w_ready_next;

    // Per-player request view
    logic [XY_W-1:0]     w_x [2];
    logic [XY_W-1:0]     w_y [2];
    logic [1:0]          w_req;
    logic [1:0]          w_dat;
    logic [1:0]          w_in_range;
    logic [1:0]          w_elig;
    logic [ADDR_W-1:0]   w_addr [2];
    logic                w_gnt;
    logic                w_gnt_sel;

    assign w_x[0] = i_x0;
    assign w_y[0] = i_y0;
    assign w_x[1] = i_x1;
    assign w_y[1] = i_y1;
    assign w_req  = {i_req1, i_req0};
    assign w_dat  = {i_data1, i_data0};

    // A player acked this cycle is not eligible again until the next one, which
    // lets two busy players interleave at one write per cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            assign w_in_range[gi] = (w_x[gi] < W_XY) && (w_y[gi] < H_XY);
            assign w_addr[gi]     = ADDR_W'(w_x[gi]) + ADDR_W'(w_y[gi]) * ADDR_W'(WIDTH);
            assign w_elig[gi]     = w_req[gi] && !r_ack[gi];
        end
    endgenerate

    // Next-state logic: clear request beats everything, then sweep or arbitrate
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_rr_ptr_next  = r_rr_ptr;
        w_ack_next     = 2'b00;
        w_err_next     = 2'b00;
        w_wren_next    = 1'b0;
        w_addr_next    = r_addr;
        w_data_next    = r_data;
        w_ready_next   = r_ready;
        w_gnt          = 1'b0;
        w_gnt_sel      = 1'b0;

        if (i_clear_req) begin
            w_state_next   = ST_CLEAR;
            w_clr_cnt_next = '0;
            w_ready_next   = 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    w_wren_next    = 1'b1;
                    w_addr_next    = r_clr_cnt;
                    w_data_next    = CLEAR_VALUE;
                    w_ready_next   = 1'b0;
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_ADDR) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_ready_next = 1'b1;
                    // Grants start only once ready has been visible for a cycle
                    if (r_ready) begin
                        if (w_elig[0] && w_elig[1]) begin
                            w_gnt     = 1'b1;
                            w_gnt_sel = r_rr_ptr;
                        end else if (w_elig[0]) begin
                            w_gnt     = 1'b1;
                            w_gnt_sel = 1'b0;
                        end else if (w_elig[1]) begin
                            w_gnt     = 1'b1;
                            w_gnt_sel = 1'b1;
                        end
                    end
                    if (w_gnt) begin
                        w_ack_next[w_gnt_sel] = 1'b1;
                        w_rr_ptr_next         = ~w_gnt_sel;
                        if (w_in_range[w_gnt_sel]) begin
                            w_wren_next = 1'b1;
                            w_addr_next = w_addr[w_gnt_sel];
                            w_data_next = w_dat[w_gnt_sel];
                        end else begin
                            w_err_next[w_gnt_sel] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers with synchronous reset into a fresh sweep
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_rr_ptr  <= 1'b0;
            r_ack     <= 2'b00;
            r_err     <= 2'b00;
            r_wren    <= 1'b0;
            r_addr    <= '0;
            r_data    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_ack     <= w_ack_next;
            r_err     <= w_err_next;
            r_wren    <= w_wren_next;
            r_addr    <= w_addr_next;
            r_data    <= w_data_next;
            r_ready   <= w_ready_next;
        end
    end

    assign o_ack0              = r_ack[0];
    assign o_ack1              = r_ack[1];
    assign o_err0              = r_err[0];
    assign o_err1              = r_err[1];
    assign o_ram_write_address = r_addr;
    assign o_ram_write_data    = r_data;
    assign o_ram_write_enabled = r_wren;
    assign o_ready             = r_ready;

endmodule
